// File: rtl/round_robin_arbiter_32_if.sv
// Request/grant bundle for the 32-way round-robin arbiter.
// The master drives the requests and the slave (the arbiter) returns the grant.
interface round_robin_arbiter_32_if;
  logic        ena_i;
  logic [31:0] req_i;
  logic        release_i;
  logic [31:0] grant_o;
  logic [4:0]  grant_idx_o;
  logic        grant_valid_o;
  logic        timeout_o;

  modport master (
    output ena_i, req_i, release_i,
    input  grant_o, grant_idx_o, grant_valid_o, timeout_o
  );

  modport slave (
    input  ena_i, req_i, release_i,
    output grant_o, grant_idx_o, grant_valid_o, timeout_o
  );
endinterface

// File: rtl/round_robin_arbiter_32.sv
// 32-way round-robin arbiter with a rotating priority pointer, a voluntary
// release strobe and a hold-time limit that forcibly revokes long grants.
module round_robin_arbiter_32 #(
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  round_robin_arbiter_32_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  hold_q, hold_d;
  logic        timeout_q, timeout_d;

  logic [63:0] req_dbl;
  logic [31:0] req_rot;
  logic [4:0]  win_off;
  logic [4:0]  win_idx;
  logic        req_any;
  logic        voluntary_end;
  logic        hold_expired;

  // Rotate so that bit 0 is the requester at ptr; the lowest set bit wins.
  assign req_dbl = {bus.req_i, bus.req_i};
  assign req_rot = 32'(req_dbl >> ptr_q);
  assign req_any = |bus.req_i;

  always_comb begin
    win_off = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (req_rot[i]) win_off = 5'(i);
    end
  end

  assign win_idx = ptr_q + win_off;

  assign voluntary_end = bus.release_i || !bus.req_i[idx_q] || !bus.ena_i;
  assign hold_expired  = (hold_q == TIMEOUT_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= 5'd0;
      idx_q     <= 5'd0;
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ena_i && req_any) begin
          state_d = GRANT;
          idx_d   = win_idx;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (voluntary_end || hold_expired) begin
          // Any owner-side cause of the exit masks the timeout pulse.
          state_d   = IDLE;
          ptr_d     = idx_q + 5'd1;
          idx_d     = 5'd0;
          hold_d    = 8'd0;
          timeout_d = !voluntary_end;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.grant_valid_o = (state_q == GRANT);
    bus.grant_idx_o   = idx_q;
    bus.timeout_o     = timeout_q;
    bus.grant_o       = 32'd0;
    if (state_q == GRANT) bus.grant_o[idx_q] = 1'b1;
  end
endmodule
